// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/active decodes, frame pulse and frame counter.
// Define VTG_RUNTIME_CFG_EN to build the cfg_* handshake that swaps timing at frame end.
`timescale 1ns/1ps
module video_timing_gen #(
  parameter int   CNT_W        = 12,
  parameter int   FC_W         = 6,
  parameter int   FPS          = 60,
  parameter int   DEF_H_ACTIVE = 1280,
  parameter int   DEF_H_FP     = 110,
  parameter int   DEF_H_SYNC   = 40,
  parameter int   DEF_H_BP     = 220,
  parameter int   DEF_V_ACTIVE = 720,
  parameter int   DEF_V_FP     = 5,
  parameter int   DEF_V_SYNC   = 5,
  parameter int   DEF_V_BP     = 20,
  parameter logic DEF_HS_POL   = 1'b1,
  parameter logic DEF_VS_POL   = 1'b1
) (
  input  logic             pixel_clk_in,
  input  logic             rst_n_in,
  input  logic             cfg_valid_in,
  output logic             cfg_ready_out,
  input  logic [CNT_W-1:0] cfg_h_active_in,
  input  logic [CNT_W-1:0] cfg_h_fp_in,
  input  logic [CNT_W-1:0] cfg_h_sync_in,
  input  logic [CNT_W-1:0] cfg_h_bp_in,
  input  logic [CNT_W-1:0] cfg_v_active_in,
  input  logic [CNT_W-1:0] cfg_v_fp_in,
  input  logic [CNT_W-1:0] cfg_v_sync_in,
  input  logic [CNT_W-1:0] cfg_v_bp_in,
  input  logic             cfg_hs_pol_in,
  input  logic             cfg_vs_pol_in,
  output logic             cfg_err_out,
  output logic             cfg_applied_out,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             ad_out,
  output logic             nf_out,
  output logic             ls_out,
  output logic [FC_W-1:0]  fc_out
);
  localparam int CFG_W = 8 * CNT_W + 2;
  localparam logic [CFG_W-1:0] DEF_CFG = {
    CNT_W'(DEF_H_ACTIVE), CNT_W'(DEF_H_FP), CNT_W'(DEF_H_SYNC), CNT_W'(DEF_H_BP),
    CNT_W'(DEF_V_ACTIVE), CNT_W'(DEF_V_FP), CNT_W'(DEF_V_SYNC), CNT_W'(DEF_V_BP),
    DEF_HS_POL, DEF_VS_POL};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   TOT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [FC_W-1:0]  FC_ZERO  = {FC_W{1'b0}};
  localparam logic [FC_W-1:0]  FC_ONE   = {{(FC_W-1){1'b0}}, 1'b1};
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FPS - 1);

  logic [CFG_W-1:0] live_cfg_s;
  logic [CNT_W-1:0] h_act_s, h_fp_s, h_sync_s, h_bp_s;
  logic [CNT_W-1:0] v_act_s, v_fp_s, v_sync_s, v_bp_s;
  logic             hs_pol_s, vs_pol_s;
  logic [CNT_W:0]   h_tot_s, v_tot_s, hs_beg_s, hs_end_s, vs_beg_s, vs_end_s, hc_w_s, vc_w_s;
  logic             h_last_s, v_last_s, frame_end_s, nf_hit_s;
  logic [CNT_W-1:0] hcount_r, vcount_r;
  logic [FC_W-1:0]  fc_r;
  logic             nf_r;

  assign {h_act_s, h_fp_s, h_sync_s, h_bp_s,
          v_act_s, v_fp_s, v_sync_s, v_bp_s, hs_pol_s, vs_pol_s} = live_cfg_s;

  // Totals and sync windows are one bit wider so a full 2^CNT_W line still fits.
  assign h_tot_s  = {1'b0, h_act_s} + {1'b0, h_fp_s} + {1'b0, h_sync_s} + {1'b0, h_bp_s};
  assign v_tot_s  = {1'b0, v_act_s} + {1'b0, v_fp_s} + {1'b0, v_sync_s} + {1'b0, v_bp_s};
  assign hs_beg_s = {1'b0, h_act_s} + {1'b0, h_fp_s};
  assign hs_end_s = hs_beg_s + {1'b0, h_sync_s};
  assign vs_beg_s = {1'b0, v_act_s} + {1'b0, v_fp_s};
  assign vs_end_s = vs_beg_s + {1'b0, v_sync_s};
  assign hc_w_s   = {1'b0, hcount_r};
  assign vc_w_s   = {1'b0, vcount_r};

  assign h_last_s    = (hc_w_s == (h_tot_s - TOT_ONE));
  assign v_last_s    = (vc_w_s == (v_tot_s - TOT_ONE));
  assign frame_end_s = h_last_s && v_last_s;
  assign nf_hit_s    = (hcount_r == h_act_s) && (vcount_r == v_act_s);

  // Raster position counters
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_r <= CNT_ZERO;
      vcount_r <= CNT_ZERO;
    end else if (h_last_s) begin
      hcount_r <= CNT_ZERO;
      vcount_r <= v_last_s ? CNT_ZERO : (vcount_r + CNT_ONE);
    end else begin
      hcount_r <= hcount_r + CNT_ONE;
    end
  end

  // New-frame pulse and free-running frame counter (untouched by timing changes)
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      nf_r <= 1'b0;
      fc_r <= FC_ZERO;
    end else begin
      nf_r <= nf_hit_s;
      if (nf_hit_s) begin
        fc_r <= (fc_r == FC_LAST) ? FC_ZERO : (fc_r + FC_ONE);
      end
    end
  end

`ifdef VTG_RUNTIME_CFG_EN
  localparam logic [0:0]       ST_RUN  = 1'b0;
  localparam logic [0:0]       ST_PEND = 1'b1;
  localparam logic [CNT_W+1:0] TOT_MAX = {2'b01, {CNT_W{1'b0}}};

  logic [0:0]       state_r;
  logic [CFG_W-1:0] live_cfg_r, shadow_cfg_r, cfg_in_s;
  logic [CNT_W+1:0] cfg_h_tot_s, cfg_v_tot_s;
  logic             cfg_ok_s, err_r, applied_r;

  assign cfg_in_s = {cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in,
                     cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in,
                     cfg_hs_pol_in, cfg_vs_pol_in};
  assign cfg_h_tot_s = {2'b00, cfg_h_active_in} + {2'b00, cfg_h_fp_in}
                     + {2'b00, cfg_h_sync_in} + {2'b00, cfg_h_bp_in};
  assign cfg_v_tot_s = {2'b00, cfg_v_active_in} + {2'b00, cfg_v_fp_in}
                     + {2'b00, cfg_v_sync_in} + {2'b00, cfg_v_bp_in};

  // An offer is usable only if every active/sync region is non-empty and the frame fits the counters
  always_comb begin
    cfg_ok_s = 1'b1;
    if ((cfg_h_active_in == CNT_ZERO) || (cfg_h_sync_in == CNT_ZERO) ||
        (cfg_v_active_in == CNT_ZERO) || (cfg_v_sync_in == CNT_ZERO) ||
        (cfg_h_tot_s > TOT_MAX) || (cfg_v_tot_s > TOT_MAX)) begin
      cfg_ok_s = 1'b0;
    end else begin
      cfg_ok_s = 1'b1;
    end
  end

  // RUN/PEND handshake: capture into shadow, swap into live on the last pixel of a frame
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= ST_RUN;
      live_cfg_r   <= DEF_CFG;
      shadow_cfg_r <= DEF_CFG;
      err_r        <= 1'b0;
      applied_r    <= 1'b0;
    end else begin
      err_r     <= 1'b0;
      applied_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (cfg_valid_in) begin
            if (cfg_ok_s) begin
              shadow_cfg_r <= cfg_in_s;
              state_r      <= ST_PEND;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (frame_end_s) begin
            live_cfg_r <= shadow_cfg_r;
            applied_r  <= 1'b1;
            state_r    <= ST_RUN;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign live_cfg_s      = live_cfg_r;
  assign cfg_ready_out   = (state_r == ST_RUN);
  assign cfg_err_out     = err_r;
  assign cfg_applied_out = applied_r;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = ^{cfg_valid_in, cfg_h_active_in, cfg_h_fp_in, cfg_h_sync_in, cfg_h_bp_in,
                          cfg_v_active_in, cfg_v_fp_in, cfg_v_sync_in, cfg_v_bp_in,
                          cfg_hs_pol_in, cfg_vs_pol_in, frame_end_s};
  assign live_cfg_s      = DEF_CFG;
  assign cfg_ready_out   = 1'b0;
  assign cfg_err_out     = 1'b0;
  assign cfg_applied_out = 1'b0;
`endif

  assign hcount_out = hcount_r;
  assign vcount_out = vcount_r;
  assign hs_out     = ((hc_w_s >= hs_beg_s) && (hc_w_s < hs_end_s)) ? hs_pol_s : ~hs_pol_s;
  assign vs_out     = ((vc_w_s >= vs_beg_s) && (vc_w_s < vs_end_s)) ? vs_pol_s : ~vs_pol_s;
  assign ad_out     = (hcount_r < h_act_s) && (vcount_r < v_act_s);
  assign ls_out     = (hcount_r == CNT_ZERO);
  assign nf_out     = nf_r;
  assign fc_out     = fc_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-position reference model predicts every cycle,
// a monitor compares DUT outputs against the predictions and against directed expectations.
`timescale 1ns/1ps
module tb_video_timing_gen;
  localparam int CNT_W = 8;
  localparam int FC_W  = 3;
  localparam int FPS   = 4;
  localparam int WD_CYCLES = 60000;
`ifdef VTG_RUNTIME_CFG_EN
  localparam bit RTCFG = 1'b1;
`else
  localparam bit RTCFG = 1'b0;
`endif

  typedef struct { int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp; } tim_t;
  typedef struct packed {
    logic [CNT_W-1:0] hc, vc;
    logic hs, vs, ad, nf, ls;
    logic [FC_W-1:0] fc;
    logic rdy, err, app;
  } obs_t;
  typedef struct { string nm; int got; int exp; } dchk_t;

  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0;
  logic [CNT_W-1:0] c_ha = '0, c_hf = '0, c_hs = '0, c_hb = '0, c_va = '0, c_vf = '0, c_vs = '0, c_vb = '0;
  logic c_hp = 1'b0, c_vp = 1'b0;
  logic cfg_ready, cfg_err, cfg_applied, hs, vs, ad, nf, ls;
  logic [CNT_W-1:0] hcount, vcount;
  logic [FC_W-1:0] fc;

  video_timing_gen #(
    .CNT_W(CNT_W), .FC_W(FC_W), .FPS(FPS),
    .DEF_H_ACTIVE(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
    .DEF_V_ACTIVE(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
    .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1)
  ) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .cfg_valid_in(cfg_valid), .cfg_ready_out(cfg_ready),
    .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
    .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
    .cfg_hs_pol_in(c_hp), .cfg_vs_pol_in(c_vp),
    .cfg_err_out(cfg_err), .cfg_applied_out(cfg_applied),
    .hcount_out(hcount), .vcount_out(vcount),
    .hs_out(hs), .vs_out(vs), .ad_out(ad), .nf_out(nf), .ls_out(ls), .fc_out(fc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int obs_nf = 0, obs_ad = 0, obs_err = 0, obs_app = 0;
  int fc_log[$];
  obs_t exp_q[$];
  dchk_t dir_q[$];

  tim_t m_live, m_shadow;
  bit m_pend, m_nf, m_err, m_app, m_acc_evt, m_rej_evt, started;
  int m_pos, m_fc;

  function automatic tim_t mk(int ha, int hf, int hs_, int hb, int va, int vf, int vs_, int vb, bit hp, bit vp);
    tim_t t;
    t.ha = ha; t.hf = hf; t.hs = hs_; t.hb = hb; t.va = va; t.vf = vf; t.vs = vs_; t.vb = vb;
    t.hp = hp; t.vp = vp;
    return t;
  endfunction

  function automatic int htot(tim_t t); return t.ha + t.hf + t.hs + t.hb; endfunction
  function automatic int vtot(tim_t t); return t.va + t.vf + t.vs + t.vb; endfunction

  function automatic bit cfg_ok(tim_t t);
    return (t.ha > 0) && (t.hs > 0) && (t.va > 0) && (t.vs > 0) &&
           (htot(t) <= (1 << CNT_W)) && (vtot(t) <= (1 << CNT_W));
  endfunction

  // Expected outputs derived from the frame position and the active timing
  function automatic obs_t expect_now();
    obs_t o;
    int ht, x, y;
    ht = htot(m_live);
    x = m_pos % ht;
    y = m_pos / ht;
    o.hc  = CNT_W'(x);
    o.vc  = CNT_W'(y);
    o.hs  = (x >= m_live.ha + m_live.hf && x < m_live.ha + m_live.hf + m_live.hs) ? m_live.hp : !m_live.hp;
    o.vs  = (y >= m_live.va + m_live.vf && y < m_live.va + m_live.vf + m_live.vs) ? m_live.vp : !m_live.vp;
    o.ad  = (x < m_live.ha) && (y < m_live.va);
    o.nf  = m_nf;
    o.ls  = (x == 0);
    o.fc  = FC_W'(m_fc);
    o.rdy = RTCFG && !m_pend;
    o.err = m_err;
    o.app = m_app;
    return o;
  endfunction

  // Reference model: one prediction per clock, reset handled asynchronously
  always @(posedge clk or negedge rst_n) begin : model_b
    int tot;
    bit last, hit;
    tim_t c;
    started = 1'b1;
    if (!rst_n) begin
      m_live = mk(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1);
      m_shadow = m_live;
      m_pend = 0; m_pos = 0; m_fc = 0; m_nf = 0; m_err = 0; m_app = 0;
      m_acc_evt = 0; m_rej_evt = 0;
      exp_q.delete();
    end else begin
      tot  = htot(m_live) * vtot(m_live);
      last = (m_pos == tot - 1);
      hit  = (m_pos == m_live.va * htot(m_live) + m_live.ha);
      m_err = 0; m_app = 0; m_acc_evt = 0; m_rej_evt = 0;
      if (RTCFG) begin
        if (m_pend) begin
          if (last) begin m_live = m_shadow; m_pend = 0; m_app = 1; end
        end else if (cfg_valid) begin
          c = mk(c_ha, c_hf, c_hs, c_hb, c_va, c_vf, c_vs, c_vb, c_hp, c_vp);
          if (cfg_ok(c)) begin m_shadow = c; m_pend = 1; m_acc_evt = 1; end
          else begin m_err = 1; m_rej_evt = 1; end
        end
      end
      m_pos = last ? 0 : m_pos + 1;
      m_nf = hit;
      if (hit) m_fc = (m_fc + 1) % FPS;
    end
    exp_q.push_back(expect_now());
  end

  // Monitor: compares every cycle against the model, drains directed checks, enforces the watchdog
  always @(negedge clk) begin : monitor_b
    obs_t got_v, exp_v;
    dchk_t d;
    cyc++;
    if (started) begin
      got_v = {hcount, vcount, hs, vs, ad, nf, ls, fc, cfg_ready, cfg_err, cfg_applied};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_empty t=%0t no prediction queued", $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL sb t=%0t got hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b ls=%b fc=%0d rdy=%b err=%b app=%b exp hc=%0d vc=%0d hs=%b vs=%b ad=%b nf=%b ls=%b fc=%0d rdy=%b err=%b app=%b",
                   $time, got_v.hc, got_v.vc, got_v.hs, got_v.vs, got_v.ad, got_v.nf, got_v.ls, got_v.fc,
                   got_v.rdy, got_v.err, got_v.app, exp_v.hc, exp_v.vc, exp_v.hs, exp_v.vs, exp_v.ad,
                   exp_v.nf, exp_v.ls, exp_v.fc, exp_v.rdy, exp_v.err, exp_v.app);
        end
      end
      if (nf) begin obs_nf++; fc_log.push_back(int'(fc)); end
      obs_ad  += int'(ad);
      obs_err += int'(cfg_err);
      obs_app += int'(cfg_applied);
    end
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      checks++;
      if (d.got != d.exp) begin
        failures++;
        $display("FAIL %s got=%0d exp=%0d", d.nm, d.got, d.exp);
      end
    end
    if (cyc > WD_CYCLES) begin
      failures++;
      $display("FAIL watchdog cycles=%0d limit=%0d", cyc, WD_CYCLES);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    dchk_t d;
    d.nm = nm; d.got = got; d.exp = exp;
    dir_q.push_back(d);
  endtask

  task automatic step(); @(posedge clk); #1; endtask
  task automatic run(input int n); for (int i = 0; i < n; i++) step(); endtask

  task automatic set_cfg(input tim_t t);
    c_ha = CNT_W'(t.ha); c_hf = CNT_W'(t.hf); c_hs = CNT_W'(t.hs); c_hb = CNT_W'(t.hb);
    c_va = CNT_W'(t.va); c_vf = CNT_W'(t.vf); c_vs = CNT_W'(t.vs); c_vb = CNT_W'(t.vb);
    c_hp = t.hp; c_vp = t.vp;
  endtask

  // Hold the offer until accepted or rejected (bounded)
  task automatic offer(input tim_t t, output bit done);
    int budget;
    budget = RTCFG ? 1500 : 4;
    set_cfg(t);
    cfg_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (m_acc_evt || m_rej_evt) done = 1'b1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_frame_end();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (m_pos == htot(m_live) * vtot(m_live) - 1) found = 1'b1;
    end
    chk("frame_end_wait", int'(found), 1);
  endtask

  function automatic tim_t rand_tim();
    return mk($urandom_range(20, 1), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom_range(8, 1), $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endfunction

  initial begin : stim_b
    bit done;
    int n0, k;
    tim_t t;
    run(3);
    rst_n = 1'b1;

    // power-on timing: one nf per 120-cycle frame
    n0 = obs_nf;
    run(240);
    chk("nf_per_2frames", obs_nf - n0, 2);
    chk("ready_idle", int'(cfg_ready), int'(RTCFG));

    // zero sync width is rejected
    n0 = obs_err;
    offer(mk(8, 2, 0, 2, 4, 1, 2, 1, 1'b1, 1'b1), done);
    run(2);
    chk("err_pulses", obs_err - n0, RTCFG ? 1 : 0);
    chk("err_ready", int'(cfg_ready), int'(RTCFG));

    // small runtime timing with inverted polarity
    n0 = obs_app;
    offer(mk(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0), done);
    chk("offer_small", int'(done), int'(RTCFG));
    for (int i = 0; i < 400 && obs_app == n0; i++) step();
    chk("applied_small", obs_app - n0, RTCFG ? 1 : 0);
    n0 = obs_ad;
    run(htot(m_live) * vtot(m_live));
    chk("ad_per_frame", obs_ad - n0, 32);

    // offer landing on the frame-end cycle applies one full frame later; PEND offers ignored
    wait_frame_end();
    set_cfg(mk(10, 2, 2, 2, 5, 1, 1, 1, 1'b1, 1'b0));
    cfg_valid = 1'b1;
    step();
    set_cfg(mk(6, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1));
    k = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      if (i == 21) cfg_valid = 1'b0;
      step();
      if (cfg_applied) k = i;
    end
    cfg_valid = 1'b0;
    chk("apply_latency", k, RTCFG ? 98 : 0);
    run(20);

    // reset while a config is pending discards it
    offer(mk(12, 1, 1, 1, 6, 1, 1, 1, 1'b0, 1'b1), done);
    run($urandom_range(50, 10));
    rst_n = 1'b0;
    #2;
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
    chk("rst_ready", int'(cfg_ready), int'(RTCFG));
    run(2);
    rst_n = 1'b1;
    fc_log.delete();
    run(605);
    chk("fc_pulses", fc_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fc_seq%0d", i), (fc_log.size() > i) ? fc_log[i] : -1, (i + 1) % FPS);

    // randomized offers, including an oversize line and an exact 2^CNT_W line
    for (int it = 0; it < 10; it++) begin
      if (it == 3) t = mk(200, 50, 5, 10, 2, 1, 1, 1, 1'b1, 1'b1);
      else if (it == 5) t = mk(200, 46, 5, 5, 1, 0, 1, 0, 1'b0, 1'b1);
      else t = rand_tim();
      offer(t, done);
      chk($sformatf("offer_rand%0d", it), int'(done), int'(RTCFG));
      run($urandom_range(300, 0));
      if ($urandom_range(4, 0) == 0) begin
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
      end
    end
    run(700);
    run(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
